// File: rtl/audio_sample_router.sv
// Audio sample router: per-sample FSM choosing passthrough, square tone,
// moving-average filter or mute between the CODEC ADC FIFO and the DAC FIFO.
module audio_sample_router #(
    parameter int unsigned           DATA_W    = 24,
    parameter int unsigned           LOG2_N    = 3,
    parameter int unsigned           TONE_HALF = 56,
    parameter logic [DATA_W-1:0]     TONE_AMP  = DATA_W'(24'h100000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              filt_full
);

    localparam int unsigned N      = 1 << LOG2_N;
    localparam int unsigned PTR_W  = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int unsigned CNT_W  = LOG2_N + 1;
    localparam int unsigned TCNT_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [1:0] M_PASS = 2'b00;
    localparam logic [1:0] M_TONE = 2'b01;
    localparam logic [1:0] M_FILT = 2'b10;

    typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                cur_mode_q, cur_mode_d;
    logic [DATA_W-1:0]         wd_l_q, wd_l_d, wd_r_q, wd_r_d;
    logic [TCNT_W-1:0]         tone_cnt_q, tone_cnt_d;
    logic                      tone_pol_q, tone_pol_d;
    logic signed [DATA_W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [DATA_W-1:0]  buf_l_q [N];
    logic signed [DATA_W-1:0]  buf_l_d [N];
    logic signed [DATA_W-1:0]  buf_r_q [N];
    logic signed [DATA_W-1:0]  buf_r_d [N];
    logic [PTR_W-1:0]          wptr_q, wptr_d;
    logic [CNT_W-1:0]          fill_q, fill_d;
    logic signed [DATA_W-1:0]  s_l, s_r, old_l, old_r;
    logic [DATA_W-1:0]         tone_sample;

    // Pre-scaled filter inputs: each sample is divided by N before summing.
    assign s_l = $signed(readdata_left)  >>> LOG2_N;
    assign s_r = $signed(readdata_right) >>> LOG2_N;

    assign tone_sample     = tone_pol_q ? (DATA_W'(0) - TONE_AMP) : TONE_AMP;
    assign writedata_left  = wd_l_q;
    assign writedata_right = wd_r_q;
    assign filt_full       = (fill_q == CNT_W'(N));

    // Next-state, handshake strobes and datapath updates.
    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        wd_l_d     = wd_l_q;
        wd_r_d     = wd_r_q;
        tone_cnt_d = tone_cnt_q;
        tone_pol_d = tone_pol_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        wptr_d     = wptr_q;
        fill_d     = fill_q;
        old_l      = '0;
        old_r      = '0;
        read       = 1'b0;
        write      = 1'b0;

        case (state_q)
            IDLE: begin
                cur_mode_d = mode;
                // Entering filter mode starts from an empty window.
                if (mode == M_FILT && cur_mode_q != M_FILT) begin
                    for (int i = 0; i < int'(N); i++) begin
                        buf_l_d[i] = '0;
                        buf_r_d[i] = '0;
                    end
                    acc_l_d = '0;
                    acc_r_d = '0;
                    wptr_d  = '0;
                    fill_d  = '0;
                end
                if (mode == M_PASS || mode == M_FILT) begin
                    if (read_ready && write_ready) begin
                        read    = 1'b1;
                        state_d = EMIT;
                        if (mode == M_PASS) begin
                            wd_l_d = readdata_left;
                            wd_r_d = readdata_right;
                        end else begin
                            if (fill_d == CNT_W'(N)) begin
                                old_l = buf_l_d[wptr_d];
                                old_r = buf_r_d[wptr_d];
                            end
                            acc_l_d = acc_l_d + s_l - old_l;
                            acc_r_d = acc_r_d + s_r - old_r;
                            buf_l_d[wptr_d] = s_l;
                            buf_r_d[wptr_d] = s_r;
                            wptr_d = (wptr_d == PTR_W'(N - 1)) ? '0 : wptr_d + PTR_W'(1);
                            if (fill_d != CNT_W'(N)) begin
                                fill_d = fill_d + CNT_W'(1);
                            end
                            wd_l_d = acc_l_d;
                            wd_r_d = acc_r_d;
                        end
                    end
                end else begin
                    // ADC is drained and discarded so it cannot overflow.
                    read = read_ready;
                    if (write_ready) begin
                        state_d = EMIT;
                        if (mode == M_TONE) begin
                            wd_l_d = tone_sample;
                            wd_r_d = tone_sample;
                            if (tone_cnt_q == TCNT_W'(TONE_HALF - 1)) begin
                                tone_cnt_d = '0;
                                tone_pol_d = ~tone_pol_q;
                            end else begin
                                tone_cnt_d = tone_cnt_q + TCNT_W'(1);
                            end
                        end else begin
                            wd_l_d = '0;
                            wd_r_d = '0;
                        end
                    end
                end
            end
            EMIT: begin
                write = write_ready;
                if (write_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_mode_q <= M_PASS;
            wd_l_q     <= '0;
            wd_r_q     <= '0;
            tone_cnt_q <= '0;
            tone_pol_q <= 1'b0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            wptr_q     <= '0;
            fill_q     <= '0;
            for (int i = 0; i < int'(N); i++) begin
                buf_l_q[i] <= '0;
                buf_r_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_mode_q <= cur_mode_d;
            wd_l_q     <= wd_l_d;
            wd_r_q     <= wd_r_d;
            tone_cnt_q <= tone_cnt_d;
            tone_pol_q <= tone_pol_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            wptr_q     <= wptr_d;
            fill_q     <= fill_d;
            for (int i = 0; i < int'(N); i++) begin
                buf_l_q[i] <= buf_l_d[i];
                buf_r_q[i] <= buf_r_d[i];
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_router.sv
// Directed bench for audio_sample_router (DATA_W=24, LOG2_N=3, TONE_HALF=4).
module tb_audio_sample_router;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        read_ready, write_ready;
    logic [23:0] readdata_left, readdata_right;
    logic        read, write, filt_full;
    logic [23:0] writedata_left, writedata_right;

    int checks = 0;
    int errors = 0;

    audio_sample_router #(
        .DATA_W(24), .LOG2_N(3), .TONE_HALF(4), .TONE_AMP(24'h100000)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .read_ready(read_ready), .write_ready(write_ready),
        .readdata_left(readdata_left), .readdata_right(readdata_right),
        .read(read), .write(write),
        .writedata_left(writedata_left), .writedata_right(writedata_right),
        .filt_full(filt_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        rr;
        logic        wr;
        logic [23:0] rl;
        logic [23:0] rd;
        logic        e_read;
        logic        e_write;
        logic [23:0] e_wl;
        logic [23:0] e_wr;
        logic        e_full;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then settle.
    task automatic cyc(input logic [1:0] m, input logic rr, input logic wr,
                       input logic [23:0] l, input logic [23:0] r);
        @(negedge clk);
        mode = m; read_ready = rr; write_ready = wr;
        readdata_left = l; readdata_right = r;
        #1;
    endtask

    task automatic chk_all(input string name, input logic e_rd, input logic e_wr,
                           input logic [23:0] e_l, input logic [23:0] e_r, input logic e_f);
        chk({name, ".read"},  24'(read),  24'(e_rd));
        chk({name, ".write"}, 24'(write), 24'(e_wr));
        chk({name, ".wd_l"},  writedata_left,  e_l);
        chk({name, ".wd_r"},  writedata_right, e_r);
        chk({name, ".full"},  24'(filt_full), 24'(e_f));
    endtask

    initial begin
        logic [23:0] exp_v;

        // passthrough, latency 1, alternating read/write
        tbl[0]  = '{2'b00, 1, 1, 24'h000123, 24'hFFF000, 1, 0, 24'h000000, 24'h000000, 0};
        tbl[1]  = '{2'b00, 1, 1, 24'h000123, 24'hFFF000, 0, 1, 24'h000123, 24'hFFF000, 0};
        tbl[2]  = '{2'b00, 1, 1, 24'h000456, 24'h000789, 1, 0, 24'h000123, 24'hFFF000, 0};
        tbl[3]  = '{2'b00, 1, 1, 24'h000456, 24'h000789, 0, 1, 24'h000456, 24'h000789, 0};
        // tone: four +A loads then -A; read mirrors read_ready
        tbl[4]  = '{2'b01, 1, 1, 24'hAAAAAA, 24'h555555, 1, 0, 24'h000456, 24'h000789, 0};
        tbl[5]  = '{2'b01, 1, 1, 24'hAAAAAA, 24'h555555, 0, 1, 24'h100000, 24'h100000, 0};
        tbl[6]  = '{2'b01, 1, 1, 24'hAAAAAA, 24'h555555, 1, 0, 24'h100000, 24'h100000, 0};
        tbl[7]  = '{2'b01, 1, 1, 24'hAAAAAA, 24'h555555, 0, 1, 24'h100000, 24'h100000, 0};
        tbl[8]  = '{2'b01, 0, 1, 24'h123456, 24'h654321, 0, 0, 24'h100000, 24'h100000, 0};
        tbl[9]  = '{2'b01, 0, 1, 24'h123456, 24'h654321, 0, 1, 24'h100000, 24'h100000, 0};
        tbl[10] = '{2'b01, 0, 1, 24'h123456, 24'h654321, 0, 0, 24'h100000, 24'h100000, 0};
        tbl[11] = '{2'b01, 0, 1, 24'h123456, 24'h654321, 0, 1, 24'h100000, 24'h100000, 0};
        tbl[12] = '{2'b01, 1, 0, 24'h123456, 24'h654321, 1, 0, 24'h100000, 24'h100000, 0};
        tbl[13] = '{2'b01, 0, 1, 24'h123456, 24'h654321, 0, 0, 24'h100000, 24'h100000, 0};
        tbl[14] = '{2'b01, 0, 1, 24'h123456, 24'h654321, 0, 1, 24'hF00000, 24'hF00000, 0};
        // mute, and idle with DAC full
        tbl[15] = '{2'b11, 1, 1, 24'h777777, 24'h777777, 1, 0, 24'hF00000, 24'hF00000, 0};
        tbl[16] = '{2'b11, 1, 1, 24'h777777, 24'h777777, 0, 1, 24'h000000, 24'h000000, 0};
        tbl[17] = '{2'b11, 1, 0, 24'h777777, 24'h777777, 1, 0, 24'h000000, 24'h000000, 0};
        tbl[18] = '{2'b00, 1, 0, 24'h777777, 24'h777777, 0, 0, 24'h000000, 24'h000000, 0};

        reset = 1'b1; mode = 2'b00; read_ready = 1'b0; write_ready = 1'b0;
        readdata_left = '0; readdata_right = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("reset", 0, 0, 24'h0, 24'h0, 0);

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].mode, tbl[i].rr, tbl[i].wr, tbl[i].rl, tbl[i].rd);
            chk_all($sformatf("vec%0d", i), tbl[i].e_read, tbl[i].e_write,
                    tbl[i].e_wl, tbl[i].e_wr, tbl[i].e_full);
        end

        // filter ramp with constant positive input, then saturated window
        for (int k = 1; k <= 10; k++) begin
            cyc(2'b10, 1, 1, 24'h000800, 24'h000800);
            chk($sformatf("fpos%0d.read", k), 24'(read), 24'd1);
            cyc(2'b10, 1, 1, 24'h000800, 24'h000800);
            exp_v = 24'(((k >= 8) ? 8 : k) * 256);
            chk_all($sformatf("fpos%0d", k), 0, 1, exp_v, exp_v, k >= 8);
        end

        // passthrough keeps the filter window; full stays up
        cyc(2'b00, 1, 1, 24'hFFF800, 24'hFFF800);
        chk("pass_mid.read", 24'(read), 24'd1);
        cyc(2'b00, 1, 1, 24'hFFF800, 24'hFFF800);
        chk_all("pass_mid", 0, 1, 24'hFFF800, 24'hFFF800, 1);

        // re-entry clears the window; negative ramp, mode flips to 00 in the last EMIT
        for (int k = 1; k <= 4; k++) begin
            cyc(2'b10, 1, 1, 24'hFFF800, 24'hFFF800);
            chk($sformatf("fneg%0d.full_before", k), 24'(filt_full), 24'(k == 1));
            cyc((k == 4) ? 2'b00 : 2'b10, 1, 1, 24'hFFF800, 24'hFFF800);
            exp_v = 24'(-(k * 256));
            chk_all($sformatf("fneg%0d", k), 0, 1, exp_v, exp_v, 0);
        end
        cyc(2'b00, 1, 1, 24'h000800, 24'h000800);
        chk("toggle_pass.read", 24'(read), 24'd1);
        cyc(2'b00, 1, 1, 24'h000800, 24'h000800);
        chk_all("toggle_pass", 0, 1, 24'h000800, 24'h000800, 0);
        cyc(2'b10, 1, 1, 24'h000800, 24'h000800);
        cyc(2'b10, 1, 1, 24'h000800, 24'h000800);
        chk_all("filt_restart", 0, 1, 24'h000100, 24'h000100, 0);

        // DAC back-pressure in EMIT: hold data, no strobes, single write on release
        cyc(2'b00, 1, 1, 24'h0ABCDE, 24'h012345);
        chk("stall.read", 24'(read), 24'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(2'b00, 1, 0, 24'h111111, 24'h222222);
            chk_all($sformatf("stall%0d", k), 0, 0, 24'h0ABCDE, 24'h012345, 0);
        end
        cyc(2'b00, 1, 1, 24'h111111, 24'h222222);
        chk_all("stall_rel", 0, 1, 24'h0ABCDE, 24'h012345, 0);
        cyc(2'b00, 1, 1, 24'h111111, 24'h222222);
        chk_all("stall_idle", 1, 0, 24'h0ABCDE, 24'h012345, 0);
        cyc(2'b00, 0, 1, 24'h111111, 24'h222222);
        chk_all("stall_next", 0, 1, 24'h111111, 24'h222222, 0);

        // reset while EMIT holds a -A tone sample; tone restarts at +A
        cyc(2'b01, 0, 1, 24'h0, 24'h0);
        chk("rst_load.write", 24'(write), 24'd0);
        cyc(2'b01, 0, 0, 24'h0, 24'h0);
        chk("rst_pend.wd_l", writedata_left, 24'hF00000);
        reset = 1'b1;
        cyc(2'b01, 0, 1, 24'h0, 24'h0);
        reset = 1'b0;
        #1;
        chk_all("rst_after", 0, 0, 24'h0, 24'h0, 0);
        cyc(2'b01, 0, 1, 24'h0, 24'h0);
        chk_all("rst_tone", 0, 1, 24'h100000, 24'h100000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
